// File: rtl/scan_dff_set_reset_pkg.sv
// Shared DFT definitions for the scannable set/reset register.
package scan_dff_set_reset_pkg;

  // Meaning of the scan-enable pin.
  typedef enum logic {
    SCAN_FUNC  = 1'b0,
    SCAN_SHIFT = 1'b1
  } scan_mode_e;

  // Next-state data selector of one scan cell: serial input in shift mode,
  // functional data otherwise.
  function automatic logic scan_mux(input logic se, input logic d, input logic si);
    return (scan_mode_e'(se) == SCAN_SHIFT) ? si : d;
  endfunction

endpackage

// File: rtl/scan_dff_set_reset_bit.sv
// One scan cell: d/si mux followed by a flop with async reset and async set.
module scan_dff_set_reset_bit
  import scan_dff_set_reset_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic ck,
  input  logic rst,
  input  logic sn,
  input  logic se,
  input  logic d,
  input  logic si,
  output logic q
);

  logic q_d;
  logic q_q;
  logic set_a;

  // The set request is qualified with reset deasserted. When reset drops
  // while sn is still low this produces a fresh rising edge, so the set
  // re-applies immediately instead of leaving the reset value behind.
  assign set_a = ~sn & ~rst;

  // Next value on a clock edge: scan or functional data.
  always_comb begin
    q_d = scan_mux(se, d, si);
  end

  // State flop: reset beats set, set beats the clock.
  always_ff @(posedge ck or posedge rst or posedge set_a) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else if (set_a) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/scan_dff_set_reset.sv
// WIDTH-bit scannable register with async active-high reset, async
// active-low set, true/complement outputs and a serial scan chain si -> so.
module scan_dff_set_reset
  import scan_dff_set_reset_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sn,
  input  logic             se,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             so
);

  // Serial input seen by each cell: si for bit 0, the lower neighbour's q
  // for every other bit, so a shift moves data towards the MSB.
  logic [WIDTH-1:0] chain_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_head
      assign chain_in[i] = si;
    end else begin : g_link
      assign chain_in[i] = q[i-1];
    end

    scan_dff_set_reset_bit #(
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .ck  (ck),
      .rst (rst),
      .sn  (sn),
      .se  (se),
      .d   (d[i]),
      .si  (chain_in[i]),
      .q   (q[i])
    );
  end

  assign qn = ~q;
  assign so = q[WIDTH-1];

endmodule

// File: tb/tb_scan_dff_set_reset.sv
// Bench for scan_dff_set_reset: a 4-bit instance with zero reset value, a
// 4-bit instance with a non-zero reset value, and a 1-bit instance, all on
// shared control pins and checked against a priority-rule reference model.
module tb_scan_dff_set_reset;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       ck;
  logic       rst;
  logic       sn;
  logic       se;
  logic       si;
  logic [3:0] d4;
  logic       d1;

  logic [3:0] q4,  qn4;
  logic       so4;
  logic [3:0] q4b, qn4b;
  logic       so4b;
  logic [0:0] q1,  qn1;
  logic       so1;

  int vectors;
  int miscompares;

  // reference model state
  logic [3:0] m4, m4b, m1;
  bit         m_valid;

  localparam logic [3:0] RV_A = 4'b0000;
  localparam logic [3:0] RV_B = 4'b0110;

  scan_dff_set_reset #(.WIDTH(4), .RESET_VAL(RV_A)) dut4 (
    .ck(ck), .rst(rst), .sn(sn), .se(se), .d(d4), .si(si),
    .q(q4), .qn(qn4), .so(so4)
  );

  scan_dff_set_reset #(.WIDTH(4), .RESET_VAL(RV_B)) dut4b (
    .ck(ck), .rst(rst), .sn(sn), .se(se), .d(d4), .si(si),
    .q(q4b), .qn(qn4b), .so(so4b)
  );

  scan_dff_set_reset #(.WIDTH(1)) dut1 (
    .ck(ck), .rst(rst), .sn(sn), .se(se), .d(d1), .si(si),
    .q(q1), .qn(qn1), .so(so1)
  );

  // ---------------- reference model ----------------
  // Priority: reset value, else all-ones while set is low, else on a rising
  // edge either load d or shift (value*2 + si, truncated to the width),
  // else hold.
  function automatic logic [3:0] ref_next(input logic [3:0] cur, input logic [3:0] rv,
                                          input int w, input logic r, input logic s,
                                          input logic rise, input logic mode,
                                          input logic [3:0] dv, input logic sv);
    int mask;
    mask = (1 << w) - 1;
    if (r) return rv & 4'(mask);
    if (!s) return 4'(mask);
    if (rise) begin
      if (mode) return 4'(((int'(cur) * 2) + int'(sv)) & mask);
      return dv & 4'(mask);
    end
    return cur;
  endfunction

  task automatic model_update(input logic rise);
    m4  = ref_next(m4,  RV_A, 4, rst, sn, rise, se, d4, si);
    m4b = ref_next(m4b, RV_B, 4, rst, sn, rise, se, d4, si);
    m1  = ref_next(m1,  4'b0, 1, rst, sn, rise, se, {3'b0, d1}, si);
    if (rst || !sn) m_valid = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    if (m_valid) begin
      chk({tag, ".q4"},   q4,                m4);
      chk({tag, ".qn4"},  qn4,               ~m4);
      chk({tag, ".so4"},  {3'b0, so4},       {3'b0, m4[3]});
      chk({tag, ".q4b"},  q4b,               m4b);
      chk({tag, ".qn4b"}, qn4b,              ~m4b);
      chk({tag, ".so4b"}, {3'b0, so4b},      {3'b0, m4b[3]});
      chk({tag, ".q1"},   {3'b0, q1},        {3'b0, m1[0]});
      chk({tag, ".qn1"},  {3'b0, qn1},       {3'b0, ~m1[0]});
      chk({tag, ".so1"},  {3'b0, so1},       {3'b0, m1[0]});
    end
  endtask

  // ---------------- driver ----------------
  // Data/control pins settle first, then the clock pin moves, so a rising
  // edge never races with the data it samples.
  task automatic drive(input string tag, input logic r, input logic s, input logic mode,
                       input logic [3:0] dv, input logic sv, input logic c);
    logic rise;
    rst = r; sn = s; se = mode; d4 = dv; d1 = dv[0]; si = sv;
    #1;
    model_update(1'b0);
    rise = c && !ck;
    ck = c;
    #1;
    model_update(rise);
    check_all(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] sseq;
    vectors = 0; miscompares = 0;
    m4 = '0; m4b = '0; m1 = '0; m_valid = 1'b0;
    ck = 1'b0; rst = 1'b0; sn = 1'b1; se = 1'b0; si = 1'b0; d4 = '0; d1 = 1'b0;
    #2;

    // async reset, then load 1111, then reset with ck held low
    drive("rst0",  1, 1, 0, 4'hF, 0, 0);
    chk("rst0.lit", q4, 4'b0000);
    drive("load1", 0, 1, 0, 4'hF, 0, 1);
    drive("load1", 0, 1, 0, 4'hF, 0, 0);
    chk("load1.lit", q4, 4'b1111);
    drive("rst1",  1, 1, 0, 4'hF, 0, 0);
    chk("rst1.lit_q",  q4,  4'b0000);
    chk("rst1.lit_qn", qn4, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      drive("rst_hold", 1, 1, 0, 4'hA, 0, 1);
      drive("rst_hold", 1, 1, 0, 4'hA, 0, 0);
    end
    chk("rst_hold.lit", q4, 4'b0000);

    // async set and its priority against reset
    drive("set",      0, 0, 0, 4'hA, 0, 0);
    chk("set.lit_qn", qn4, 4'b0000);
    drive("set_rst",  1, 0, 0, 4'hA, 0, 0);
    chk("set_rst.lit", q4b, 4'b0110);
    drive("rst_rel",  0, 0, 0, 4'hA, 0, 0);
    chk("rst_rel.lit", q4, 4'b1111);
    drive("set_rel",  0, 1, 0, 4'hA, 0, 0);
    chk("set_rel.lit", q4, 4'b1111);

    // functional load; d moves without an edge
    drive("func",     0, 1, 0, 4'hA, 0, 1);
    chk("func.lit", q4, 4'b1010);
    drive("func_hold", 0, 1, 0, 4'h5, 0, 1);
    drive("func_hold", 0, 1, 0, 4'h5, 0, 0);
    chk("func_hold.lit", q4, 4'b1010);

    // scan shift of 1,0,1,1 into a cleared register, random d ignored
    drive("scan_clr", 1, 1, 1, 4'h5, 0, 0);
    sseq = 4'b1011;
    for (int k = 3; k >= 0; k--) begin
      drive("scan", 0, 1, 1, 4'($urandom_range(0, 15)), sseq[k], 1);
      drive("scan", 0, 1, 1, 4'($urandom_range(0, 15)), sseq[k], 0);
    end
    chk("scan.lit", q4, 4'b1011);

    // reset pulse between edges in the middle of a shift
    drive("mid_shift", 0, 1, 1, 4'h0, 1, 1);
    drive("mid_rst",   1, 1, 1, 4'h0, 1, 1);
    chk("mid_rst.lit", q4, 4'b0000);
    drive("mid_rel",   0, 1, 1, 4'h0, 1, 1);
    drive("mid_rel",   0, 1, 1, 4'h0, 1, 0);
    drive("mid_after", 0, 1, 1, 4'h0, 1, 1);
    chk("mid_after.lit", q4, 4'b0001);

    // binary-order sweep of {d, rst, se, si, sn, ck}
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      drive("sweep", v[4], v[1], v[3], {4{v[5]}}, v[2], v[0]);
    end

    // random traffic with occasional reset and set pulses
    for (int i = 0; i < 300; i++) begin
      drive("rand",
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 11) != 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            ~ck);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
